// File: rtl/divider_arbiter.sv
// Round-robin arbiter in front of a shared, unreset, fixed-latency divider.
// A tag pipeline follows the divider and routes each result back to its requester.
module divider_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DIVIDEND_WIDTH = 12,
    parameter int DIVISOR_WIDTH  = 6,
    parameter int DIV_LATENCY    = 14
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                pause,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ*DIVIDEND_WIDTH-1:0]   req_dividend,
    input  logic [NUM_REQ*DIVISOR_WIDTH-1:0]    req_divisor,
    output logic [NUM_REQ-1:0]                  req_ready,
    output logic                                div_input_valid,
    output logic [DIVIDEND_WIDTH-1:0]           div_dividend,
    output logic [DIVISOR_WIDTH-1:0]            div_divisor,
    input  logic                                div_output_valid,
    input  logic [DIVIDEND_WIDTH-1:0]           div_quotient,
    input  logic [DIVIDEND_WIDTH-1:0]           div_remainder,
    output logic                                resp_valid,
    output logic [$clog2(NUM_REQ)-1:0]          resp_id,
    output logic [DIVIDEND_WIDTH-1:0]           resp_quotient,
    output logic [DIVIDEND_WIDTH-1:0]           resp_remainder,
    output logic                                resp_div_zero,
    output logic [$clog2(DIV_LATENCY+3)-1:0]    in_flight,
    output logic                                sync_error
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(DIV_LATENCY + 1);

    typedef enum logic {FLUSH, RUN} state_t;

    state_t                  state;
    logic [CW-1:0]           flush_cnt;
    logic [IDW-1:0]          rr_ptr;
    logic [IDW-1:0]          grant_id;
    logic [IDW-1:0]          scan_id;
    logic [IDW-1:0]          issue_id;
    logic                    grant_any;
    logic [DIV_LATENCY-1:0]  tag_v;
    logic [DIV_LATENCY-1:0]  tag_z;
    logic [IDW-1:0]          tag_id [DIV_LATENCY];
    logic                    head_v;
    logic                    head_z;
    logic [IDW-1:0]          head_id;

    assign head_v  = tag_v[DIV_LATENCY-1];
    assign head_z  = tag_z[DIV_LATENCY-1];
    assign head_id = tag_id[DIV_LATENCY-1];

    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        scan_id   = '0;
        req_ready = '0;
        if (state == RUN && !pause) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                scan_id = IDW'((32'(rr_ptr) + k) % 32'(NUM_REQ));
                if (!grant_any && req_valid[scan_id]) begin
                    grant_any = 1'b1;
                    grant_id  = scan_id;
                end
            end
        end
        if (grant_any) req_ready[grant_id] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= FLUSH;
            flush_cnt       <= '0;
            rr_ptr          <= '0;
            issue_id        <= '0;
            div_input_valid <= 1'b0;
            div_dividend    <= '0;
            div_divisor     <= '0;
            tag_v           <= '0;
            tag_z           <= '0;
            for (int unsigned i = 0; i < DIV_LATENCY; i++) tag_id[i] <= '0;
            resp_valid      <= 1'b0;
            resp_id         <= '0;
            resp_quotient   <= '0;
            resp_remainder  <= '0;
            resp_div_zero   <= 1'b0;
            in_flight       <= '0;
            sync_error      <= 1'b0;
        end else begin
            // Hold off grants until anything issued before reset has left the divider.
            if (state == FLUSH) begin
                if (flush_cnt == CW'(DIV_LATENCY)) state <= RUN;
                else flush_cnt <= flush_cnt + 1'b1;
            end

            div_input_valid <= grant_any;
            if (grant_any) begin
                div_dividend <= req_dividend[int'(grant_id)*DIVIDEND_WIDTH +: DIVIDEND_WIDTH];
                div_divisor  <= req_divisor[int'(grant_id)*DIVISOR_WIDTH +: DIVISOR_WIDTH];
                issue_id     <= grant_id;
                rr_ptr       <= (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
            end

            // Tags are loaded from the issue registers so the head lines up with div_output_valid.
            tag_v <= {tag_v[DIV_LATENCY-2:0], div_input_valid};
            tag_z <= {tag_z[DIV_LATENCY-2:0], div_divisor == '0};
            for (int unsigned i = DIV_LATENCY - 1; i > 0; i--) tag_id[i] <= tag_id[i-1];
            tag_id[0] <= issue_id;

            resp_valid <= head_v;
            if (head_v) begin
                resp_id        <= head_id;
                resp_div_zero  <= head_z;
                resp_quotient  <= head_z ? '1 : div_quotient;
                resp_remainder <= head_z ? '0 : div_remainder;
            end

            if (state == RUN && head_v != div_output_valid) sync_error <= 1'b1;

            if (grant_any && !resp_valid)      in_flight <= in_flight + 1'b1;
            else if (!grant_any && resp_valid) in_flight <= in_flight - 1'b1;
        end
    end
endmodule

// File: doc/divider_arbiter.md
DIVIDER_ARBITER -- requirements
Module: divider_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning), one per line:
- NUM_REQ, 4, number of requesters, 2..8.
- DIVIDEND_WIDTH, 12, signed dividend width.
- DIVISOR_WIDTH, 6, unsigned divisor width.
- DIV_LATENCY, 14, cycles from div_input_valid to div_output_valid (DIVIDEND_WIDTH+2).
REQ-002 Ports SHALL be (name, direction, width, meaning), one per line:
- clock, in, 1, single clock, rising edge.
- reset, in, 1, synchronous, active-high.
- pause, in, 1, when high no new grants are issued.
- req_valid, in, NUM_REQ, per-requester request.
- req_dividend, in, NUM_REQ*DIVIDEND_WIDTH, packed, requester i at [i*W +: W].
- req_divisor, in, NUM_REQ*DIVISOR_WIDTH, packed likewise.
- req_ready, out, NUM_REQ, one-hot or zero grant.
- div_input_valid, out, 1, to shared divider.
- div_dividend, out, DIVIDEND_WIDTH, to divider.
- div_divisor, out, DIVISOR_WIDTH, to divider.
- div_output_valid, in, 1, from divider.
- div_quotient, in, DIVIDEND_WIDTH, from divider.
- div_remainder, in, DIVIDEND_WIDTH, from divider.
- resp_valid, out, 1, result strobe, no backpressure.
- resp_id, out, $clog2(NUM_REQ), requester owning the result.
- resp_quotient, out, DIVIDEND_WIDTH, result quotient.
- resp_remainder, out, DIVIDEND_WIDTH, result remainder.
- resp_div_zero, out, 1, result came from a zero divisor.
- in_flight, out, $clog2(DIV_LATENCY+3), operations issued but not yet responded.
- sync_error, out, 1, sticky divider/tag mismatch.

Function
REQ-003 States SHALL be FLUSH and RUN; reset enters FLUSH; FLUSH -> RUN after exactly DIV_LATENCY+1 cycles, counted by an internal counter.
REQ-004 In FLUSH, req_ready SHALL be 0 and div_output_valid SHALL be ignored, so the unreset divider pipeline drains.
REQ-005 In RUN with pause low, the grant SHALL go to the first requester with req_valid high, searching from rr_ptr upward modulo NUM_REQ; the grant is combinational, and req_ready is asserted only for the granted index.
REQ-006 On a handshake (req_valid[i] & req_ready[i]) at edge T, rr_ptr SHALL become (i+1) mod NUM_REQ; with no handshake rr_ptr holds.
REQ-007 div_input_valid, div_dividend and div_divisor SHALL be registered, asserting in cycle T+1 with the granted operands; with no handshake div_input_valid is 0 and the operands hold.
REQ-008 A tag shift register of depth DIV_LATENCY SHALL travel alongside the divider pipeline, carrying {valid, id, zero_flag}; zero_flag = (divisor == 0).
REQ-009 When a tag reaches the head with valid=1, the arbiter SHALL register the response:
- resp_valid=1 and resp_id=id one cycle after div_output_valid, i.e. total latency DIV_LATENCY+2 from handshake (16 at defaults).
- Quotient and remainder are passed through from the divider.
REQ-010 If zero_flag=1, resp_quotient SHALL be all-ones, resp_remainder SHALL be 0, resp_div_zero SHALL be 1, and the divider data is discarded.
REQ-011 In RUN, a head tag valid bit that differs from div_output_valid SHALL set sync_error; sync_error clears only on reset, and responses continue to follow the tag.
REQ-012 in_flight SHALL increment on a handshake and decrement on resp_valid; simultaneous events leave it unchanged; it never exceeds DIV_LATENCY+2.
REQ-013 Throughput SHALL be one operation per cycle with results in issue order.
REQ-014 pause SHALL block new grants only; in-flight operations complete normally.
REQ-015 req_valid dropping without a handshake SHALL be legal; the arbiter holds no per-request state before the grant.

Reset
REQ-016 On reset high at any clock edge, including mid-operation, the following SHALL hold:
- state=FLUSH, flush counter=0, rr_ptr=0.
- All tag valid bits are 0 and in_flight=0.
- div_input_valid=0, div_dividend=0, div_divisor=0.
- resp_valid=0, resp_id=0, resp_quotient=0, resp_remainder=0, resp_div_zero=0, sync_error=0.
REQ-017 Operations in flight at reset SHALL be dropped silently, producing no response and no sync_error.

Verification
REQ-018 Release reset, all req_valid=1 -> req_ready=0 for 15 cycles, first grant to requester 0 in cycle 16.
REQ-019 After flush, requester 2 issues 100/7 -> 16 cycles later resp_valid=1, resp_id=2, resp_quotient=14 (rounded divider), in_flight back to 0.
REQ-020 All four requesters hold req_valid=1 for 8 cycles -> grants 0,1,2,3,0,1,2,3 and responses in the same id order on consecutive cycles.
REQ-021 Requester 1 issues -50/0 -> resp_quotient=12'hFFF, resp_remainder=0, resp_div_zero=1, resp_id=1.
REQ-022 Reset asserted with 5 operations in flight -> no resp_valid afterwards, in_flight=0, sync_error=0, and a new FLUSH period.
REQ-023 Force a spurious div_output_valid in RUN with no tag -> sync_error=1 and held until reset.
